mv_seq_ctrl: RTL and testbench
==============================

# mv_seq_ctrl

Parametrised command sequencer for the matrix-vector systolic array, replacing the fixed CSR-driven controller. It decodes a word stream of 16-bit commands from the SPI front end, loads the vector and matrix into the shared operand memory, and drives per-PE fetch addresses and the array's reset and read controls. It then writes results back to memory and streams them out on request. It adds programmable dimensions, error flagging and result readback.

## Interface
- WORD_SIZE, 16, command/data word width
- ADDR_SIZE, 13, memory address width
- PE_NUMBER, 64, PE count and maximum rows/cols (at most 64)
- DIM_W, 6, dimension field width (log2 PE_NUMBER)
- VEC_BASE, 13'h0000, vector base address
- MAT_BASE, 13'h0040, matrix base address
- RES_BASE, 13'h1040, result base address
- ZERO_ADDR, 13'h1fff, address reading constant zero
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle strobe; cmd_data valid; no back-pressure
- cmd_data  in  WORD_SIZE  command or data word
- w_en / w_addr / w_data  out  1 / ADDR_SIZE / WORD_SIZE  memory write port
- rd_en / rd_addr  out  1 / ADDR_SIZE  memory read port
- rd_data  in  WORD_SIZE  read data, one cycle after rd_en
- vec_rd_addr  out  ADDR_SIZE  vector operand address
- mat_rd_addr  out  PE_NUMBER*ADDR_SIZE  per-PE matrix address; PE i at [i*ADDR_SIZE +: ADDR_SIZE]
- arr_reset  out  1  array clear
- arr_read  out  1  array result shift-out
- res_data  in  WORD_SIZE  array result word while arr_read=1
- resp_valid / resp_data  out  1 / WORD_SIZE  readback stream
- busy / done / err  out  1  status: state≠IDLE / one-cycle completion pulse / sticky protocol error

## Operation
- Header opcode is cmd_data[15:12]:
  - 2 SET_DIM: rows=cmd_data[11:6]+1, cols=cmd_data[5:0]+1; also clears err.
  - 3 START_CAL.
  - 4 WRITE_VEC.
  - 5 WRITE_MAT.
  - 6 READ_RESULT.
  - Other opcodes: ignored.
- Headers are decoded only in IDLE.
- States: IDLE, LOAD_VEC, LOAD_MAT, FETCH, CAL, DRAIN, READ, DONE.
- LOAD_VEC: takes the next `rows` words; word k is written to VEC_BASE+k. Opcode bits are not decoded. Returns to IDLE after the last word.
- LOAD_MAT: takes `rows*cols` words; word n is written to MAT_BASE+n, column-major (n=c*rows+r).
- FETCH: lasts `rows` cycles, k=0..rows-1.
  - vec_rd_addr=VEC_BASE+k.
  - mat_rd_addr[i]=MAT_BASE+i*rows+k for i<cols, otherwise ZERO_ADDR.
- CAL: lasts rows+cols-1 cycles; all fetch addresses are ZERO_ADDR.
- DRAIN: lasts `cols` cycles with arr_read=1. res_data sampled in drain cycle j is written to RES_BASE+j.
- DONE: one cycle; done=1; then IDLE.
- READ: issues rd_en at RES_BASE+j for j=0..cols-1. resp_valid/resp_data replay rd_data one cycle later. Exits to IDLE after the last response.
- cmd_valid in FETCH, CAL, DRAIN, DONE or READ: the word is dropped and err is set.
- Address arithmetic is modulo 2^ADDR_SIZE. Counters are at least 13 bits wide so rows*cols=4096 does not overflow.

## Timing
- Reset values:
  - arr_reset=1.
  - vec_rd_addr and all mat_rd_addr = ZERO_ADDR.
  - All other outputs 0.
  - rows=cols=1; state IDLE.
- Reset is asynchronous at any point. A partial load or compute is abandoned and memory contents are untouched.
- All outputs are registered.
- Header at cycle t: the new state is active at t+1.
- Data word at cycle t: w_en/w_addr/w_data are valid at t+1.
- START_CAL at t:
  - FETCH occupies t+1..t+rows; arr_reset=0 from t+1.
  - CAL follows for rows+cols-1 cycles, then DRAIN for cols cycles.
  - Writes lag drain sampling by one cycle.
  - done pulses the cycle after the last write.
  - arr_reset returns to 1 on IDLE re-entry.
- busy=1 in every non-IDLE state, LOAD states included.
- READ_RESULT at t: rd_en asserts t+1..t+cols; resp_valid asserts t+2..t+cols+1.
- SET_DIM during a LOAD state is consumed as data and does not change dimensions.
- w_en from a load never coincides with w_en from a drain; they occur in exclusive states.

## Test plan
- Reset with rst_n=0 mid-FETCH -> immediately arr_reset=1, mat_rd_addr all 13'h1fff, busy=0. Memory shows no writes.
- SET_DIM 16'h20C3 (rows=4, cols=4), WRITE_VEC followed by 4 words -> writes to 0x0000..0x0003; busy falls the cycle after the 4th write.
- WRITE_MAT followed by 16 words -> writes to 0x0040..0x004F in order. A 17th word arriving in IDLE is decoded as a header.
- START_CAL with rows=4, cols=4 -> FETCH k=2 gives vec_rd_addr=0x0002 and PE1 at 0x0046; PE4..PE63 stay at 0x1fff. DRAIN gives 4 writes at 0x1040..0x1043. done arrives 4+7+4+1 cycles after the header, plus one.
- START_CAL sent during CAL -> err=1, the sequence is unaffected. A subsequent SET_DIM clears err.
- READ_RESULT with cols=64 -> exactly 64 resp_valid pulses, data equal to memory 0x1040..0x107F, first response two cycles after the header.

Source files
------------

// File: rtl/mv_seq_ctrl.sv
// mv_seq_ctrl: command sequencer for the matrix-vector systolic array.
// Loads operands, steps fetch/compute/drain, and streams results back.
module mv_seq_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 13,
  parameter int PE_NUMBER = 64,
  parameter int DIM_W     = 6,
  parameter logic [ADDR_SIZE-1:0] VEC_BASE  = 13'h0000,
  parameter logic [ADDR_SIZE-1:0] MAT_BASE  = 13'h0040,
  parameter logic [ADDR_SIZE-1:0] RES_BASE  = 13'h1040,
  parameter logic [ADDR_SIZE-1:0] ZERO_ADDR = 13'h1fff
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  input  logic [WORD_SIZE-1:0]           cmd_data,
  output logic                           w_en,
  output logic [ADDR_SIZE-1:0]           w_addr,
  output logic [WORD_SIZE-1:0]           w_data,
  output logic                           rd_en,
  output logic [ADDR_SIZE-1:0]           rd_addr,
  input  logic [WORD_SIZE-1:0]           rd_data,
  output logic [ADDR_SIZE-1:0]           vec_rd_addr,
  output logic [PE_NUMBER*ADDR_SIZE-1:0] mat_rd_addr,
  output logic                           arr_reset,
  output logic                           arr_read,
  input  logic [WORD_SIZE-1:0]           res_data,
  output logic                           resp_valid,
  output logic [WORD_SIZE-1:0]           resp_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  typedef enum logic [2:0] {
    IDLE, LOAD_VEC, LOAD_MAT, FETCH,
    CAL, DRAIN, READ, DONE
  } state_t;

  localparam logic [3:0] OP_DIM = 4'd2;
  localparam logic [3:0] OP_CAL = 4'd3;
  localparam logic [3:0] OP_VEC = 4'd4;
  localparam logic [3:0] OP_MAT = 4'd5;
  localparam logic [3:0] OP_RD  = 4'd6;

  localparam logic [DIM_W:0]     DIM_ONE  = 1;
  localparam logic [ADDR_SIZE-1:0] A_ONE  = 1;
  localparam logic [ADDR_SIZE-1:0] A_TWO  = 2;

  state_t                 state;
  logic [DIM_W:0]         rows;
  logic [DIM_W:0]         cols;
  logic [ADDR_SIZE-1:0]   cnt;
  logic [ADDR_SIZE-1:0]   mat_q [PE_NUMBER];

  logic [3:0]             op;
  logic [ADDR_SIZE-1:0]   rows_a;
  logic [ADDR_SIZE-1:0]   cols_a;
  logic [ADDR_SIZE-1:0]   rows_last;
  logic [ADDR_SIZE-1:0]   cols_last;
  logic [ADDR_SIZE-1:0]   mat_last;
  logic [ADDR_SIZE-1:0]   cal_last;
  logic                   no_cmd;

  assign op        = cmd_data[WORD_SIZE-1 -: 4];
  assign rows_a    = ADDR_SIZE'(rows);
  assign cols_a    = ADDR_SIZE'(cols);
  assign rows_last = rows_a - A_ONE;
  assign cols_last = cols_a - A_ONE;
  assign mat_last  = rows_a * cols_a - A_ONE;
  assign cal_last  = rows_a + cols_a - A_TWO;

  // states in which an incoming word is a protocol error
  assign no_cmd = (state == FETCH) || (state == CAL) ||
                  (state == DRAIN) || (state == DONE) ||
                  (state == READ);

  for (genvar g = 0; g < PE_NUMBER; g++) begin : g_pe
    assign mat_rd_addr[g*ADDR_SIZE +: ADDR_SIZE] = mat_q[g];
  end

  // sequencer: state, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rows        <= DIM_ONE;
      cols        <= DIM_ONE;
      cnt         <= '0;
      w_en        <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      vec_rd_addr <= ZERO_ADDR;
      arr_reset   <= 1'b1;
      arr_read    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < PE_NUMBER; i++)
        mat_q[i] <= ZERO_ADDR;
    end else begin
      w_en       <= 1'b0;
      done       <= 1'b0;
      resp_valid <= 1'b0;
      if (cmd_valid && no_cmd)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            unique case (1'b1)
              (op == OP_DIM): begin
                rows <= {1'b0, cmd_data[2*DIM_W-1 -: DIM_W]}
                        + DIM_ONE;
                cols <= {1'b0, cmd_data[DIM_W-1:0]} + DIM_ONE;
                err  <= 1'b0;
              end
              (op == OP_CAL): begin
                state       <= FETCH;
                busy        <= 1'b1;
                arr_reset   <= 1'b0;
                cnt         <= '0;
                vec_rd_addr <= VEC_BASE;
                for (int i = 0; i < PE_NUMBER; i++)
                  mat_q[i] <= (ADDR_SIZE'(i) < cols_a) ?
                    MAT_BASE + ADDR_SIZE'(i) * rows_a :
                    ZERO_ADDR;
              end
              (op == OP_VEC): begin
                state <= LOAD_VEC;
                busy  <= 1'b1;
                cnt   <= '0;
              end
              (op == OP_MAT): begin
                state <= LOAD_MAT;
                busy  <= 1'b1;
                cnt   <= '0;
              end
              (op == OP_RD): begin
                state   <= READ;
                busy    <= 1'b1;
                rd_en   <= 1'b1;
                rd_addr <= RES_BASE;
                cnt     <= '0;
              end
              default: ;
            endcase
          end
        end
        LOAD_VEC: begin
          if (cmd_valid) begin
            w_en   <= 1'b1;
            w_addr <= VEC_BASE + cnt;
            w_data <= cmd_data;
            cnt    <= cnt + A_ONE;
            if (cnt == rows_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        LOAD_MAT: begin
          if (cmd_valid) begin
            w_en   <= 1'b1;
            w_addr <= MAT_BASE + cnt;
            w_data <= cmd_data;
            cnt    <= cnt + A_ONE;
            if (cnt == mat_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (cnt == rows_last) begin
            state       <= CAL;
            cnt         <= '0;
            vec_rd_addr <= ZERO_ADDR;
            for (int i = 0; i < PE_NUMBER; i++)
              mat_q[i] <= ZERO_ADDR;
          end else begin
            cnt         <= cnt + A_ONE;
            vec_rd_addr <= vec_rd_addr + A_ONE;
            for (int i = 0; i < PE_NUMBER; i++)
              if (ADDR_SIZE'(i) < cols_a)
                mat_q[i] <= mat_q[i] + A_ONE;
          end
        end
        CAL: begin
          if (cnt == cal_last) begin
            state    <= DRAIN;
            cnt      <= '0;
            arr_read <= 1'b1;
          end else begin
            cnt <= cnt + A_ONE;
          end
        end
        DRAIN: begin
          // extra cycle after the shift-out lets the last write land
          if (arr_read) begin
            w_en   <= 1'b1;
            w_addr <= RES_BASE + cnt;
            w_data <= res_data;
            cnt    <= cnt + A_ONE;
            if (cnt == cols_last)
              arr_read <= 1'b0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          arr_reset <= 1'b1;
        end
        READ: begin
          resp_valid <= rd_en;
          if (rd_en) begin
            resp_data <= rd_data;
            if (cnt == cols_last) begin
              rd_en <= 1'b0;
            end else begin
              cnt     <= cnt + A_ONE;
              rd_addr <= rd_addr + A_ONE;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_seq_ctrl.sv
// tb_mv_seq_ctrl: randomized bench for mv_seq_ctrl.
// Expected timing and contents come from cycle-offset formulas.
module tb_mv_seq_ctrl;

  localparam int AW   = 13;
  localparam int PN   = 64;
  localparam int VEC  = 'h0000;
  localparam int MAT  = 'h0040;
  localparam int RES  = 'h1040;
  localparam int ZERO = 'h1fff;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic [15:0]     cmd_data;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [15:0]     w_data;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [15:0]     rd_data;
  logic [AW-1:0]   vec_rd_addr;
  logic [PN*AW-1:0] mat_rd_addr;
  logic            arr_reset;
  logic            arr_read;
  logic [15:0]     res_data;
  logic            resp_valid;
  logic [15:0]     resp_data;
  logic            busy;
  logic            done;
  logic            err;

  mv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .vec_rd_addr(vec_rd_addr), .mat_rd_addr(mat_rd_addr),
    .arr_reset(arr_reset), .arr_read(arr_read),
    .res_data(res_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem    [8192];
  logic [15:0] refmem [8192];
  int nwr = 0;

  assign rd_data = mem[rd_addr];

  always @(posedge clk)
    if (w_en) begin
      mem[w_addr] <= w_data;
      nwr <= nwr + 1;
    end

  int total = 0;
  int bad   = 0;
  int R = 1;
  int C = 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] pe(input int i);
    return mat_rd_addr[i*AW +: AW];
  endfunction

  task automatic idle();
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] w);
    cmd_valid = 1'b1;
    cmd_data  = w;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic set_dim(input int r, input int c);
    logic [5:0] rf, cf;
    rf = 6'(r - 1);
    cf = 6'(c - 1);
    send({4'h2, rf, cf});
    R = r;
    C = c;
    chk("dim_err", err, 0);
    chk("dim_busy", busy, 0);
  endtask

  task automatic load(input bit is_mat);
    int n, a;
    logic [15:0] w;
    n = is_mat ? R * C : R;
    send(is_mat ? 16'h5000 : 16'h4000);
    chk("ld_busy0", busy, 1);
    chk("ld_wen0", w_en, 0);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        chk("ld_gap", w_en, 0);
      end
      w = 16'($urandom);
      if (k == n / 2) w = 16'h2FFF;
      send(w);
      a = (is_mat ? MAT : VEC) + k;
      chk("ld_wen", w_en, 1);
      chk("ld_addr", w_addr, a);
      chk("ld_data", w_data, w);
      chk("ld_busy", busy, k != n - 1);
      refmem[a] = w;
    end
    idle();
    chk("ld_tail", w_en, 0);
    send(16'h0123);
    chk("ld_ign_busy", busy, 0);
    chk("ld_ign_wen", w_en, 0);
  endtask

  task automatic cal(input int inj);
    logic [15:0] resv [64];
    int last, dr0, k, j, ex;
    bit e_err, fetch, wd;
    e_err = 1'b0;
    last  = 2*R + 2*C + 2;
    dr0   = 2*R + C;
    send(16'h3000);
    for (int d = 1; d <= last; d++) begin
      fetch = (d <= R);
      k = d - 1;
      chk("c_busy", busy, d <= last - 1);
      chk("c_arst", arr_reset, d > last - 1);
      chk("c_aread", arr_read, d >= dr0 && d < dr0 + C);
      chk("c_done", done, d == last - 1);
      chk("c_vec", vec_rd_addr, fetch ? VEC + k : ZERO);
      for (int i = 0; i < PN; i++) begin
        ex = (fetch && i < C) ? MAT + i*R + k : ZERO;
        chk($sformatf("c_pe%0d", i), pe(i), ex);
      end
      wd = (d > dr0) && (d <= dr0 + C);
      chk("c_wen", w_en, wd);
      if (wd) begin
        j = d - dr0 - 1;
        chk("c_waddr", w_addr, RES + j);
        chk("c_wdata", w_data, resv[j]);
        refmem[RES + j] = resv[j];
      end
      chk("c_err", err, e_err);
      if (d >= dr0 && d < dr0 + C) begin
        res_data = 16'($urandom);
        resv[d - dr0] = res_data;
      end
      if (d == inj) begin
        cmd_valid = 1'b1;
        cmd_data  = 16'h3000;
        e_err     = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic rd();
    int n;
    n = 0;
    send(16'h6000);
    for (int d = 1; d <= C + 2; d++) begin
      chk("r_en", rd_en, d <= C);
      if (d <= C) chk("r_addr", rd_addr, RES + d - 1);
      chk("r_valid", resp_valid, d >= 2 && d <= C + 1);
      if (d >= 2 && d <= C + 1)
        chk("r_data", resp_data, refmem[RES + d - 2]);
      if (resp_valid) n++;
      chk("r_busy", busy, d <= C + 1);
      @(negedge clk);
    end
    chk("r_count", n, C);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arst"}, arr_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vec"}, vec_rd_addr, ZERO);
    chk({tag, "_pe0"}, pe(0), ZERO);
    chk({tag, "_pe1"}, pe(1), ZERO);
    chk({tag, "_pe63"}, pe(63), ZERO);
    chk({tag, "_aread"}, arr_read, 0);
    chk({tag, "_wen"}, w_en, 0);
    chk({tag, "_rden"}, rd_en, 0);
    chk({tag, "_rv"}, resp_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int w0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    res_data  = '0;
    for (int a = 0; a < 8192; a++) refmem[a] = '0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_dim(4, 4);
    load(1'b0);
    load(1'b1);
    cal(R + 1);
    chk("err_sticky", err, 1);
    rd();

    set_dim($urandom_range(1, 8), $urandom_range(1, 8));
    load(1'b0);
    load(1'b1);
    cal(0);
    rd();

    set_dim(2, 64);
    load(1'b0);
    load(1'b1);
    cal(0);
    rd();

    set_dim(64, 3);
    load(1'b0);
    load(1'b1);
    cal(0);
    rd();

    set_dim(3, 5);
    send(16'h3000);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    w0 = nwr;
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    R = 1;
    C = 1;
    @(negedge clk);
    chk("mid_nowr", nwr, w0);
    cal(0);
    rd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
